// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches from instruction memory, resolves B/BR locally
// and hands every other instruction to the decoder over valid/ready.
module instr_fetch #(
  parameter int unsigned RESET_PC = 0,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [2:0]      br_addr,
  input  logic [31:0]     br_data,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALTED} state_t;
  localparam logic [6:0] OP_B = 7'b1100000;
  localparam logic [6:0] OP_BR = 7'b1100010;
  localparam logic [6:0] OP_HALT = 7'b1101000;
  state_t state;
  logic [PC_W-1:0] pc;
  logic kill;
  logic [6:0] op;
  logic [PC_W-1:0] b_target;
  logic in_flight;
  assign op = imem_data[31:25];
  assign b_target = pc + {{(PC_W-16){imem_data[15]}}, imem_data[15:0]};
  // a redirect while a request is outstanding must swallow that response
  assign in_flight = (state == FETCH) || (state == WAIT && !imem_valid);
  assign imem_req = (state == FETCH) && !rst;
  assign imem_addr = pc;
  assign br_addr = imem_data[24:22];
  assign instr_valid = (state == ISSUE) && !redirect_en;
  assign halted = (state == HALTED);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc <= PC_W'(RESET_PC);
      kill <= 1'b0;
      instr_out <= '0;
      instr_pc <= '0;
    end else if (redirect_en) begin
      pc <= redirect_pc;
      kill <= in_flight;
      state <= in_flight ? WAIT : FETCH;
    end else begin
      case (state)
        FETCH: state <= WAIT;
        WAIT:
          if (imem_valid) begin
            kill <= 1'b0;
            if (kill) state <= FETCH;
            else if (op == OP_B) begin
              pc <= b_target;
              state <= FETCH;
            end else if (op == OP_BR) begin
              pc <= br_data[PC_W-1:0];
              state <= FETCH;
            end else if (op == OP_HALT) state <= HALTED;
            else begin
              instr_out <= imem_data;
              instr_pc <= pc;
              pc <= pc + PC_W'(1);
              state <= ISSUE;
            end
          end
        ISSUE: if (instr_ready) state <= FETCH;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: memory/register-file models, ISA-level reference interpreter
// feeding a scoreboard, directed scenarios plus randomized programs.
module tb_instr_fetch;
  localparam int PC_W = 32;
  localparam logic [6:0] OP_B = 7'b1100000, OP_BC = 7'b1100001, OP_BR = 7'b1100010;
  localparam logic [6:0] OP_NOP = 7'b1100100, OP_HALT = 7'b1101000;
  typedef struct {logic [31:0] pc; logic [31:0] word;} ent_t;
  logic clk = 1'b0, rst;
  logic imem_req, imem_valid = 1'b0;
  logic [PC_W-1:0] imem_addr, instr_pc, redirect_pc = '0;
  logic [31:0] imem_data = '0, br_data, instr_out;
  logic [2:0] br_addr;
  logic instr_valid, instr_ready, halted, redirect_en = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] regs [0:7];
  logic rnd_ready = 1'b0, rnd_bit = 1'b1, ready_val = 1'b1;
  int lat = 1, errors = 0, checks = 0, cyc = 0;
  ent_t exp_q[$];
  int issue_cyc[$], fetch_cyc[$];
  logic [31:0] fetch_addr[$];
  int cnt = 0;
  logic pend = 1'b0;
  logic [7:0] maddr = '0;

  instr_fetch #(.RESET_PC(0), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .br_addr(br_addr), .br_data(br_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .halted(halted));

  assign br_data = regs[br_addr];
  assign instr_ready = rnd_ready ? rnd_bit : ready_val;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: one outstanding request, answered lat cycles after the request cycle
  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_data = mem[maddr];
          pend = 1'b0;
        end
      end
      if (imem_req) begin
        pend = 1'b1;
        cnt = lat;
        maddr = imem_addr[7:0];
      end
    end
  end

  always @(negedge clk) begin
    rnd_bit = ($urandom_range(2) != 0);
    if (imem_req) begin
      fetch_addr.push_back(imem_addr);
      fetch_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // scoreboard monitor: a transfer happens at the next rising edge when valid & ready
  initial forever begin
    @(negedge clk);
    #3;
    if (instr_valid && instr_ready) begin
      issue_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: pc %0h word %0h", instr_pc, instr_out);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("issue_pc", instr_pc, e.pc);
        check("issue_word", instr_out, e.word);
      end
    end
  end

  // reference: walk the program at ISA level, queue every instruction the decoder should see
  task automatic model_run(input logic [31:0] start, input int max_steps);
    logic [31:0] p, w;
    bit done;
    p = start;
    done = 0;
    for (int n = 0; n < max_steps && !done; n++) begin
      w = mem[p[7:0]];
      if (w[31:25] == OP_B) p = p + {{16{w[15]}}, w[15:0]};
      else if (w[31:25] == OP_BR) p = regs[w[24:22]];
      else if (w[31:25] == OP_HALT) done = 1;
      else begin
        exp_q.push_back('{pc: p, word: w});
        p = p + 1;
      end
    end
  endtask

  function automatic logic [31:0] add_w();
    logic [31:0] w;
    w = $urandom() | 32'h1;
    if (w[30:29] == 2'b11) w[31] = 1'b0;
    else w[31:30] = 2'b00;
    return w;
  endfunction
  function automatic logic [31:0] halt_w();
    return {OP_HALT, 25'd0};
  endfunction
  function automatic logic [31:0] b_w(input logic [15:0] off);
    return {OP_B, 9'd0, off};
  endfunction
  function automatic logic [31:0] br_w(input logic [2:0] r);
    return {OP_BR, r, 22'd0};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = halt_w();
  endtask
  task automatic reset_dut();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    issue_cyc.delete();
    fetch_addr.delete();
    fetch_cyc.delete();
    clear_mem();
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, halted, 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, instr_valid, 1);
  endtask
  task automatic wait_req(input string name);
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, imem_req, 1);
  endtask
  task automatic check_fetches(input string name, input logic [31:0] exp_a[$]);
    check({name, "_count"}, fetch_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < fetch_addr.size(); i++)
      check({name, "_addr"}, fetch_addr[i], exp_a[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_pc, held_w;
    int viol;
    bit found;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) regs[k] = '0;
    clear_mem();
    @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_br_addr", br_addr, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_halted", halted, 0);

    // sequential issue, one every 3 cycles
    for (int i = 0; i < 4; i++) mem[i] = add_w();
    lat = 1;
    ready_val = 1'b1;
    model_run(0, 100);
    release_rst();
    wait_halt("seq_halt", 100);
    check("seq_first_fetch", fetch_addr[0], 0);
    check("seq_issues", issue_cyc.size(), 4);
    for (int i = 1; i < 4 && i < issue_cyc.size(); i++)
      check("seq_spacing", issue_cyc[i] - issue_cyc[i-1], 3);

    // backpressure
    reset_dut();
    mem[0] = add_w();
    mem[1] = add_w();
    ready_val = 1'b0;
    model_run(0, 100);
    release_rst();
    wait_valid("bp_valid_seen");
    held_pc = instr_pc;
    held_w = instr_out;
    check("bp_pc", held_pc, 0);
    check("bp_word", held_w, mem[0]);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", instr_valid, 1);
      check("bp_pc_stable", instr_pc, held_pc);
      check("bp_word_stable", instr_out, held_w);
      check("bp_no_req", imem_req, 0);
    end
    ready_val = 1'b1;
    @(negedge clk);
    check("bp_next_req", imem_req, 1);
    check("bp_next_addr", imem_addr, 1);
    wait_halt("bp_halt", 100);

    // B / BR chain: 0 -> 4 -> 2 -> 5 -> r3
    reset_dut();
    mem[0] = b_w(16'd4);
    mem[4] = b_w(16'hFFFE);
    mem[2] = b_w(16'd3);
    mem[5] = br_w(3'd3);
    regs[3] = 32'h40;
    mem[8'h40] = add_w();
    model_run(0, 100);
    release_rst();
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      #1;
      if (imem_valid && imem_data[31:25] == OP_BR) found = 1;
    end
    check("br_seen", found, 1);
    check("br_addr", br_addr, 3);
    wait_halt("br_halt", 100);
    check_fetches("br_fetch", '{32'h0, 32'h4, 32'h2, 32'h5, 32'h40, 32'h41});
    for (int i = 1; i < 5 && i < fetch_cyc.size(); i++)
      check("br_bubble", fetch_cyc[i] - fetch_cyc[i-1], 2);

    // HALT, then restart by redirect
    reset_dut();
    for (int i = 0; i < 6; i++) mem[i] = add_w();
    mem[8'h10] = add_w();
    model_run(0, 100);
    release_rst();
    wait_halt("halt_reach", 100);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || imem_req) viol++;
    end
    check("halt_hold", viol, 0);
    model_run(32'h10, 100);
    redirect_pc = 32'h10;
    redirect_en = 1'b1;
    @(negedge clk);
    redirect_en = 1'b0;
    check("halt_cleared", halted, 0);
    check("halt_redir_req", imem_req, 1);
    check("halt_redir_addr", imem_addr, 32'h10);
    wait_halt("halt_redir_halt", 100);

    // redirect while waiting on a 3-cycle memory
    reset_dut();
    for (int i = 0; i < 4; i++) mem[i] = add_w();
    mem[8'h80] = add_w();
    lat = 3;
    model_run(32'h80, 100);
    release_rst();
    wait_req("rw_req");
    @(negedge clk);
    redirect_pc = 32'h80;
    redirect_en = 1'b1;
    @(negedge clk);
    redirect_en = 1'b0;
    wait_halt("rw_halt", 100);
    check_fetches("rw_fetch", '{32'h0, 32'h80, 32'h81});

    // redirect in the request cycle itself
    reset_dut();
    for (int i = 0; i < 4; i++) mem[i] = add_w();
    mem[8'h80] = add_w();
    lat = 2;
    model_run(32'h80, 100);
    release_rst();
    wait_req("rf_req");
    redirect_pc = 32'h80;
    redirect_en = 1'b1;
    @(negedge clk);
    redirect_en = 1'b0;
    wait_halt("rf_halt", 100);
    check_fetches("rf_fetch", '{32'h0, 32'h80, 32'h81});

    // redirect coincident with ready in ISSUE
    reset_dut();
    mem[0] = add_w();
    mem[8'h20] = add_w();
    lat = 1;
    ready_val = 1'b0;
    release_rst();
    wait_valid("ri_valid_seen");
    model_run(32'h20, 100);
    ready_val = 1'b1;
    redirect_pc = 32'h20;
    redirect_en = 1'b1;
    #1;
    check("ri_valid_blocked", instr_valid, 0);
    @(negedge clk);
    redirect_en = 1'b0;
    check("ri_req", imem_req, 1);
    check("ri_addr", imem_addr, 32'h20);
    wait_halt("ri_halt", 100);

    // asynchronous reset in WAIT
    reset_dut();
    for (int i = 0; i < 3; i++) mem[i] = add_w();
    lat = 3;
    model_run(0, 1);
    release_rst();
    viol = 0;
    while (fetch_addr.size() < 2 && viol < 50) begin
      @(negedge clk);
      #1;
      viol++;
    end
    check("ar_second_fetch", fetch_addr.size(), 2);
    check("ar_pre_drained", exp_q.size(), 0);
    @(negedge clk);
    check("ar_pre_addr", imem_addr, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_imem_req", imem_req, 0);
    check("ar_imem_addr", imem_addr, 0);
    check("ar_instr_out", instr_out, 0);
    check("ar_instr_pc", instr_pc, 0);
    check("ar_instr_valid", instr_valid, 0);
    check("ar_halted", halted, 0);
    @(negedge clk);
    fetch_addr.delete();
    model_run(0, 100);
    release_rst();
    wait_halt("ar_halt", 200);
    check("ar_first_fetch", fetch_addr[0], 0);

    // randomized forward-only programs with random latency and backpressure
    for (int it = 0; it < 15; it++) begin
      int r;
      reset_dut();
      lat = $urandom_range(4, 1);
      for (int k = 0; k < 8; k++) regs[k] = 8 * k + 8 + $urandom_range(7);
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(15);
        mem[i] = r == 7 ? {OP_BC, 25'($urandom())} :
                 r == 8 ? {OP_NOP, 25'($urandom())} :
                 r <= 10 && r > 8 ? b_w(16'($urandom_range(4, 1))) :
                 r <= 12 && r > 10 ? br_w(3'(i / 8)) :
                 r == 13 && i > 32 ? halt_w() : add_w();
      end
      model_run(0, 400);
      rnd_ready = 1'b1;
      release_rst();
      wait_halt("rnd_halt", 6000);
      rnd_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: owns the program counter, requests words from instruction memory, resolves unconditional branches (B, BR) locally and hands every other instruction to the instruction decoder over a valid/ready handshake. It sits between instruction memory and the decoder. It accepts a PC redirect from downstream for taken Bcond and stops fetching on HALT.

## Interface
- RESET_PC, 0: PC value loaded on reset (word address).
- PC_W, 32: PC and memory address width.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request strobe, one cycle per fetch.
- imem_addr  out  PC_W  word address of the requested instruction (= pc).
- imem_valid  in  1  one-cycle pulse: imem_data holds the requested word; at least 1 cycle after imem_req.
- imem_data  in  32  instruction word.
- br_addr  out  3  register-file read address for BR (= imem_data[24:22]).
- br_data  in  32  combinational register-file read data for br_addr.
- instr_out  out  32  instruction presented to the decoder.
- instr_pc  out  PC_W  address of instr_out.
- instr_valid  out  1  instr_out/instr_pc valid.
- instr_ready  in  1  decoder accepts this cycle.
- redirect_en  in  1  taken conditional branch; load redirect_pc.
- redirect_pc  in  PC_W  redirect target.
- halted  out  1  HALT fetched; no further fetches.

## Operation
- Opcode = word[31:25]. B = 1100000, BR = 1100010, HALT = 1101000; all other encodings (including Bcond 1100001 and NOP 1100100) are issued to the decoder unchanged.
- States: FETCH, WAIT, ISSUE, HALTED. Reset enters FETCH with pc = RESET_PC.
- FETCH: imem_req = 1, imem_addr = pc; next state WAIT.
- WAIT: idle until imem_valid. On imem_valid:
  - kill flag set: clear kill, discard word, go to FETCH (pc already holds redirect target).
  - B: pc <= pc + sign_extend(word[15:0]); go to FETCH; not issued.
  - BR: pc <= br_data; go to FETCH; not issued.
  - HALT: go to HALTED; not issued; pc unchanged.
  - otherwise: instr_out <= word, instr_pc <= pc, pc <= pc + 1; go to ISSUE.
- ISSUE: instr_valid = 1; on instr_ready go to FETCH. Outputs hold stable while stalled.
- HALTED: halted = 1, imem_req = 0. Left only by reset or redirect.
- Redirect (redirect_en = 1) has priority over every event except reset, in every state:
  - pc <= redirect_pc.
  - In WAIT with no imem_valid the same cycle: set kill, stay in WAIT.
  - In WAIT with imem_valid the same cycle: discard word, go to FETCH.
  - In FETCH: the request issued this cycle is killed (set kill, go to WAIT).
  - In ISSUE: drop the held instruction, go to FETCH; instr_valid = (state == ISSUE) & ~redirect_en, so a simultaneous instr_ready never completes a transfer.
  - In HALTED: clear halted, go to FETCH.
- Arithmetic: pc addition modulo 2^PC_W; offset is 16-bit two's complement sign-extended to PC_W; BR uses br_data[PC_W-1:0].

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, br_addr 0, instr_out 0, instr_pc 0, instr_valid 0, halted 0, kill 0.
- imem_req, instr_valid, halted decode from the state register; br_addr is combinational from imem_data.
- Minimum issue latency: FETCH (1) + memory (≥1) + ISSUE (≥1). With 1-cycle memory and ready held high, one instruction is issued every 3 cycles.
- B/BR: the target fetch starts the cycle after imem_valid (2-cycle bubble for a 1-cycle memory).
- Redirect: the target's imem_req is asserted no later than the cycle after redirect_en, or the cycle after the killed response returns.
- Reset asserted mid-transaction: immediate return to reset values. A late imem_valid arriving in FETCH after reset is ignored.

## Test plan
- Sequential: RESET_PC=0, memory holds ADD words at 0..3, 1-cycle latency, ready=1 -> instr_pc 0,1,2,3 issued 3 cycles apart, instr_out matches memory.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE -> instr_valid stays 1, instr_out/instr_pc stable, imem_req stays 0; the next fetch starts the cycle after ready.
- B: B at addr 4 with offset 0xFFFE -> next imem_addr = 2, B never issued. BR at 5 with r3 = 0x40 -> br_addr = 3, next imem_addr = 0x40.
- HALT: HALT at addr 6 -> halted = 1 and imem_req stays 0 for 20 cycles; then redirect_pc = 0x10 -> halted = 0, imem_addr = 0x10.
- Redirect in flight: redirect_en with target 0x80 while WAIT on a 3-cycle memory -> the returning word is discarded and not issued, next imem_addr = 0x80. Redirect coincident with instr_ready in ISSUE -> no transfer, next fetch at target.
- Async reset asserted during WAIT -> all outputs return to reset values without a clock edge; after release, first imem_addr = RESET_PC.
